// File: rtl/idli_sqi_arb_m_pkg.sv
// rtl/idli_sqi_arb_m_pkg.sv - shared types and constants for the SQI port arbiter
package idli_pkg;

    localparam int ARB_REQ_NUM  = 2;
    localparam int SQI_WORD_NIB = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_XFER
    } arb_state_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
    } arb_req_t;

endpackage

// File: rtl/idli_sqi_arb_m_if.sv
// rtl/idli_sqi_arb_m_if.sv - requester and SQI-engine signals seen by the arbiter
interface idli_sqi_arb_if #(
    parameter int REQ_NUM = 2
);

    logic [REQ_NUM-1:0]    i_arb_req;
    logic [REQ_NUM-1:0]    i_arb_wr;
    logic [REQ_NUM*16-1:0] i_arb_addr;
    logic [REQ_NUM-1:0]    o_arb_gnt;
    logic [REQ_NUM-1:0]    o_arb_done;
    logic                  o_arb_sqi_start;
    logic                  o_arb_sqi_wr;
    logic [15:0]           o_arb_sqi_addr;
    logic                  i_arb_sqi_acp;
    logic                  i_arb_sqi_data_vld;

    modport master (
        input  i_arb_req, i_arb_wr, i_arb_addr, i_arb_sqi_acp, i_arb_sqi_data_vld,
        output o_arb_gnt, o_arb_done, o_arb_sqi_start, o_arb_sqi_wr, o_arb_sqi_addr
    );

    modport slave (
        output i_arb_req, i_arb_wr, i_arb_addr, i_arb_sqi_acp, i_arb_sqi_data_vld,
        input  o_arb_gnt, o_arb_done, o_arb_sqi_start, o_arb_sqi_wr, o_arb_sqi_addr
    );

endinterface

// File: rtl/idli_sqi_arb_m_pick.sv
// rtl/idli_sqi_arb_m_pick.sv - combinational winner select, aged requesters before fixed priority
module idli_sqi_arb_pick_m #(
    parameter int REQ_NUM = 2
) (
    input  logic [REQ_NUM-1:0] req_i,
    input  logic [REQ_NUM-1:0] aged_i,
    output logic [REQ_NUM-1:0] win_o
);

    logic [REQ_NUM-1:0] cand;
    logic               found;

    // A stale age flag on a requester that has just dropped must not win.
    always_comb begin
        cand  = (|(aged_i & req_i)) ? (aged_i & req_i) : req_i;
        win_o = '0;
        found = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (cand[i] && !found) begin
                win_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/idli_sqi_arb_m.sv
// rtl/idli_sqi_arb_m.sv - SQI port arbiter/sequencer; optional aging via IDLI_SQI_ARB_AGE_EN
module idli_sqi_arb_m
    import idli_pkg::*;
#(
    parameter int REQ_NUM  = ARB_REQ_NUM,
    parameter int AGE_MAX  = 8,
    parameter int WORD_NIB = SQI_WORD_NIB
) (
    input  logic               i_arb_gck,
    input  logic               i_arb_rst,
    idli_sqi_arb_if.master     arb
);

    localparam int CNT_W = (WORD_NIB > 1) ? $clog2(WORD_NIB) : 1;

    arb_state_t         state_q, state_d;
    logic [REQ_NUM-1:0] gnt_q, gnt_d;
    logic [REQ_NUM-1:0] done_q, done_d;
    arb_req_t           cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REQ_NUM-1:0] win;
    logic [REQ_NUM-1:0] aged;
    arb_req_t           sel;

`ifdef IDLI_SQI_ARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    assign aged[0] = 1'b0;

    for (genvar gi = 1; gi < REQ_NUM; gi++) begin : g_age
        logic [AGE_W-1:0] age_q, age_d;

        always_comb begin
            age_d = age_q;
            if (!arb.i_arb_req[gi] || gnt_q[gi]) begin
                age_d = '0;
            end else if (age_q != AGE_W'(AGE_MAX)) begin
                age_d = age_q + AGE_W'(1);
            end
        end

        always_ff @(posedge i_arb_gck) begin
            if (i_arb_rst) begin
                age_q <= '0;
            end else begin
                age_q <= age_d;
            end
        end

        assign aged[gi] = (age_q == AGE_W'(AGE_MAX));
    end
`else
    // Fixed priority only; the comparison is always false for a legal AGE_MAX.
    assign aged = {REQ_NUM{AGE_MAX < 0}};
`endif

    idli_sqi_arb_pick_m #(
        .REQ_NUM (REQ_NUM)
    ) u_pick (
        .req_i  (arb.i_arb_req),
        .aged_i (aged),
        .win_o  (win)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (win[i]) begin
                sel.wr   = arb.i_arb_wr[i];
                sel.addr = arb.i_arb_addr[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (|arb.i_arb_req) begin
                    state_d = ARB_CMD;
                    gnt_d   = win;
                    cmd_d   = sel;
                end
            end
            ARB_CMD: begin
                if (arb.i_arb_sqi_acp) begin
                    state_d = ARB_XFER;
                    cnt_d   = '0;
                end
            end
            ARB_XFER: begin
                if (arb.i_arb_sqi_data_vld) begin
                    if (cnt_q == CNT_W'(WORD_NIB - 1)) begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        done_d  = gnt_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_arb_gck) begin
        if (i_arb_rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cmd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb.o_arb_gnt       = gnt_q;
    assign arb.o_arb_done      = done_q;
    assign arb.o_arb_sqi_start = (state_q == ARB_CMD);
    assign arb.o_arb_sqi_wr    = cmd_q.wr;
    assign arb.o_arb_sqi_addr  = cmd_q.addr;

endmodule
